imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 202 ++++++++++++++++++++
 tb/tb_imem_loader.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - streams instruction words into IMEM, then enables the CPU
// Optional read-back checksum verify pass: define IMEM_LOADER_VERIFY_EN
module imem_loader #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              arst,
   input  logic              start,
   input  logic              stop,
   input  logic [31:0]       load_base,
   input  logic [ADDR_W:0]   load_count,
   input  logic              s_valid,
   input  logic [DATA_W-1:0] s_data,
   output logic              s_ready,
   output logic [31:0]       addr_ext,
   output logic              wen_ext,
   output logic              ren_ext,
   output logic [DATA_W-1:0] wdata_ext,
   input  logic [DATA_W-1:0] rdata_ext,
   output logic              cpu_enable,
   output logic              busy,
   output logic              done,
   output logic              error
);

   localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LOAD   = 2'd1,
`ifdef IMEM_LOADER_VERIFY_EN
      S_VERIFY = 2'd2,
`endif
      S_RUN    = 2'd3
   } state_t;

   state_t            r_state;
   logic [31:0]       r_base;
   logic [ADDR_W:0]   r_count;
   logic [ADDR_W:0]   r_idx;
   logic              r_s_ready;
   logic [31:0]       r_addr;
   logic              r_wen;
   logic [DATA_W-1:0] r_wdata;
   logic              r_cpu_en;
   logic              r_busy;
   logic              r_done;
   logic              r_error;

   logic              w_accept;
   logic [ADDR_W:0]   w_idx_next;
   logic [31:0]       w_wr_addr;

   assign w_accept   = (r_state == S_LOAD) && r_s_ready && s_valid;
   assign w_idx_next = r_idx + ONE;
   assign w_wr_addr  = r_base + (32'(r_idx) << 2);

`ifdef IMEM_LOADER_VERIFY_EN
   logic              r_ren;
   logic              r_rpend;
   logic [ADDR_W:0]   r_ridx;
   logic [ADDR_W:0]   r_rcnt;
   logic [DATA_W-1:0] r_wsum;
   logic [DATA_W-1:0] r_rsum;
   logic [31:0]       w_rd_addr;
   logic [DATA_W-1:0] w_rsum_next;

   assign w_rd_addr   = r_base + (32'(r_ridx) << 2);
   assign w_rsum_next = r_rsum ^ rdata_ext;
   assign ren_ext     = r_ren;
`else
   assign ren_ext     = 1'b0;
`endif

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_state   <= S_IDLE;
         r_base    <= '0;
         r_count   <= '0;
         r_idx     <= '0;
         r_s_ready <= 1'b0;
         r_addr    <= '0;
         r_wen     <= 1'b0;
         r_wdata   <= '0;
         r_cpu_en  <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_error   <= 1'b0;
`ifdef IMEM_LOADER_VERIFY_EN
         r_ren     <= 1'b0;
         r_rpend   <= 1'b0;
         r_ridx    <= '0;
         r_rcnt    <= '0;
         r_wsum    <= '0;
         r_rsum    <= '0;
`endif
      end else begin
         r_wen <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  if (load_count > DEPTH) begin
                     r_error <= 1'b1;
                  end else begin
                     r_error <= 1'b0;
                     r_base  <= load_base;
                     r_count <= load_count;
                     r_idx   <= '0;
`ifdef IMEM_LOADER_VERIFY_EN
                     r_wsum  <= '0;
`endif
                     if (load_count == '0) begin
                        r_state  <= S_RUN;
                        r_cpu_en <= 1'b1;
                        r_done   <= 1'b1;
                     end else begin
                        r_state   <= S_LOAD;
                        r_s_ready <= 1'b1;
                        r_busy    <= 1'b1;
                     end
                  end
               end
            end
            S_LOAD: begin
               if (w_accept) begin
                  r_wen     <= 1'b1;
                  r_wdata   <= s_data;
                  r_addr    <= w_wr_addr;
                  r_idx     <= w_idx_next;
                  r_s_ready <= (w_idx_next < r_count);
`ifdef IMEM_LOADER_VERIFY_EN
                  r_wsum    <= r_wsum ^ s_data;
`endif
               end else if (!r_s_ready) begin
                  // every word accepted; the final write is on the bus this cycle
`ifdef IMEM_LOADER_VERIFY_EN
                  r_state <= S_VERIFY;
                  r_ridx  <= '0;
                  r_rcnt  <= '0;
                  r_rsum  <= '0;
                  r_ren   <= 1'b0;
                  r_rpend <= 1'b0;
`else
                  r_state  <= S_RUN;
                  r_busy   <= 1'b0;
                  r_cpu_en <= 1'b1;
                  r_done   <= 1'b1;
`endif
               end
            end
`ifdef IMEM_LOADER_VERIFY_EN
            S_VERIFY: begin
               if (r_ridx < r_count) begin
                  r_ren  <= 1'b1;
                  r_addr <= w_rd_addr;
                  r_ridx <= r_ridx + ONE;
               end else begin
                  r_ren  <= 1'b0;
               end
               r_rpend <= r_ren;
               if (r_rpend) begin
                  r_rsum <= w_rsum_next;
                  r_rcnt <= r_rcnt + ONE;
                  if (r_rcnt == r_count - ONE) begin
                     r_busy <= 1'b0;
                     r_ren  <= 1'b0;
                     if (w_rsum_next == r_wsum) begin
                        r_state  <= S_RUN;
                        r_cpu_en <= 1'b1;
                        r_done   <= 1'b1;
                     end else begin
                        r_state <= S_IDLE;
                        r_error <= 1'b1;
                     end
                  end
               end
            end
`endif
            S_RUN: begin
               if (stop) begin
                  r_state  <= S_IDLE;
                  r_cpu_en <= 1'b0;
                  r_done   <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign s_ready    = r_s_ready;
   assign addr_ext   = r_addr;
   assign wen_ext    = r_wen;
   assign wdata_ext  = r_wdata;
   assign cpu_enable = r_cpu_en;
   assign busy       = r_busy;
   assign done       = r_done;
   assign error      = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized self-checking bench for imem_loader
// Expected writes are derived from base+4*k per accepted word; memory model answers reads.
`timescale 1ns/1ps
module tb_imem_loader;
   localparam int ADDR_W = 9;
   localparam int DATA_W = 32;

   logic              clk = 1'b0;
   logic              arst = 1'b1;
   logic              start = 1'b0;
   logic              stop = 1'b0;
   logic [31:0]       load_base = '0;
   logic [ADDR_W:0]   load_count = '0;
   logic              s_valid = 1'b0;
   logic [DATA_W-1:0] s_data = '0;
   logic              s_ready;
   logic [31:0]       addr_ext;
   logic              wen_ext;
   logic              ren_ext;
   logic [DATA_W-1:0] wdata_ext;
   logic [DATA_W-1:0] rdata_ext = '0;
   logic              cpu_enable;
   logic              busy;
   logic              done;
   logic              error;

   imem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .arst(arst), .start(start), .stop(stop),
      .load_base(load_base), .load_count(load_count),
      .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext),
      .wdata_ext(wdata_ext), .rdata_ext(rdata_ext),
      .cpu_enable(cpu_enable), .busy(busy), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
      int          due;
   } wr_t;

   int          n_checks = 0;
   int          n_pass = 0;
   int          cyc = 0;
   wr_t         exp_q[$];
   wr_t         log_q[$];
   logic [31:0] words[$];
   logic [31:0] mem[logic [31:0]];
   logic        rd_pend = 1'b0;
   logic [31:0] rd_addr = '0;
   logic        corrupt_en = 1'b0;
   logic [31:0] corrupt_addr = '0;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
   endtask

   // compare process: every write must match the next expected one, exactly one cycle after acceptance
   always @(negedge clk) begin
      if (!arst) begin
         if (wen_ext) log_q.push_back('{a: addr_ext, d: wdata_ext, due: cyc});
         if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            chk("wen", wen_ext, 1);
            chk("waddr", addr_ext, exp_q[0].a);
            chk("wdata", wdata_ext, exp_q[0].d);
            void'(exp_q.pop_front());
         end else if (wen_ext) begin
            chk("spurious_wen", wen_ext, 0);
         end
         if (busy) chk("busy_excl", {cpu_enable, done}, 0);
`ifndef IMEM_LOADER_VERIFY_EN
         chk("ren_tied", ren_ext, 0);
`endif
      end
   end

   always @(negedge clk) begin
      if (!arst && wen_ext) mem[addr_ext] = wdata_ext;
      rd_pend = !arst && ren_ext;
      rd_addr = addr_ext;
   end

   always @(posedge clk) begin
      #1;
      if (rd_pend && mem.exists(rd_addr))
         rdata_ext = mem[rd_addr] ^ ((corrupt_en && rd_addr == corrupt_addr) ? 32'h1 : 32'h0);
      else
         rdata_ext = $urandom;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_words(input int n);
      words.delete();
      for (int i = 0; i < n; i++) words.push_back($urandom);
   endtask

   task automatic do_start(input logic [31:0] base, input logic [ADDR_W:0] n);
      load_base  = base;
      load_count = n;
      start      = 1'b1;
      step();
      start      = 1'b0;
      load_base  = $urandom;
      load_count = (ADDR_W+1)'($urandom);
   endtask

   task automatic stream(input logic [31:0] base, input int n, input bit use_pat,
                         input logic [31:0] pat, input int abort_after);
      int k = 0;
      int t = 0;
      while (k < n && k != abort_after && t < 2000) begin
         logic sv;
         sv = use_pat ? ((t < 32) ? pat[t] : 1'b1) : ($urandom_range(0, 3) != 0);
         s_valid = sv;
         s_data  = sv ? words[k] : $urandom;
         stop    = use_pat ? 1'b0 : ($urandom_range(0, 7) == 0);
         @(negedge clk);
         chk("s_ready_load", s_ready, 1);
         step();
         if (sv) begin
            exp_q.push_back('{a: base + 32'(k) * 32'd4, d: words[k], due: cyc});
            k++;
         end
         t++;
      end
      s_valid = 1'b0;
      stop    = 1'b0;
      if (abort_after < 0) chk("words_accepted", k, n);
   endtask

   task automatic finish_load(input logic [31:0] base, input int n, input bit expect_err);
`ifdef IMEM_LOADER_VERIFY_EN
      int r = 0;
      int t = 0;
      bit fin = 0;
      while (!fin && t < 4 * n + 20) begin
         @(negedge clk);
         if (ren_ext) begin
            chk("raddr", addr_ext, base + 32'(r) * 32'd4);
            r++;
         end
         if (cpu_enable || error) fin = 1;
         else begin
            step();
            t++;
         end
      end
      chk("verify_finished", fin, 1);
      chk("verify_reads", r, n);
      chk("verify_err", error, expect_err);
      chk("verify_cpu", cpu_enable, !expect_err);
      chk("verify_busy", busy, 0);
      step();
`else
      @(negedge clk);
      chk("lastwr_ready", s_ready, 0);
      chk("lastwr_busy", busy, 1);
      chk("lastwr_cpu", cpu_enable, 0);
      step();
      @(negedge clk);
      chk("run_cpu", cpu_enable, !expect_err);
      chk("run_done", done, !expect_err);
      chk("run_busy", busy, 0);
      chk("run_err", error, expect_err);
      step();
`endif
   endtask

   task automatic do_stop();
      stop = 1'b1;
      step();
      stop = 1'b0;
      @(negedge clk);
      chk("stop_cpu", cpu_enable, 0);
      chk("stop_done", done, 0);
      chk("stop_busy", busy, 0);
      step();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

   initial begin
      logic [31:0] base;
      int n;

      @(negedge clk);
      chk("reset_outs", {s_ready, addr_ext, wen_ext, ren_ext, wdata_ext, cpu_enable, busy, done, error}, 0);
      step();
      arst = 1'b0;
      step();

      // three-instruction program, s_valid held high
      words = '{32'h20080005, 32'h20090007, 32'h01095020};
      log_q.delete();
      do_start(32'h0, 3);
      stream(32'h0, 3, 1'b1, 32'hFFFF_FFFF, -1);
      finish_load(32'h0, 3, 1'b0);
      chk("t1_nwr", log_q.size(), 3);
      if (log_q.size() >= 3) begin
         chk("t1_a0", log_q[0].a, 32'h0);
         chk("t1_a1", log_q[1].a, 32'h4);
         chk("t1_a2", log_q[2].a, 32'h8);
         chk("t1_d2", log_q[2].d, 32'h01095020);
         chk("t1_consec", log_q[2].due - log_q[0].due, 2);
      end
      do_stop();

      // s_valid pattern 1,0,0,1 over a 2-word load
      set_words(2);
      log_q.delete();
      do_start(32'h100, 2);
      stream(32'h100, 2, 1'b1, 32'b1001, -1);
      finish_load(32'h100, 2, 1'b0);
      chk("t2_nwr", log_q.size(), 2);
      if (log_q.size() >= 2) begin
         chk("t2_a0", log_q[0].a, 32'h100);
         chk("t2_a1", log_q[1].a, 32'h104);
         chk("t2_gap", log_q[1].due - log_q[0].due, 3);
      end
      do_stop();

      // zero-length load goes straight to RUN; start in RUN is ignored
      log_q.delete();
      do_start(32'h40, 0);
      @(negedge clk);
      chk("t3_cpu", cpu_enable, 1);
      chk("t3_done", done, 1);
      chk("t3_busy", busy, 0);
      load_count = 5;
      start = 1'b1;
      step();
      start = 1'b0;
      @(negedge clk);
      chk("t3_start_ign", {busy, cpu_enable}, 2'b01);
      step();
      do_stop();
      chk("t3_nwr", log_q.size(), 0);

      // oversize count
      log_q.delete();
      do_start(32'h0, 513);
      @(negedge clk);
      chk("t4_err", error, 1);
      chk("t4_idle", {s_ready, busy, cpu_enable, done}, 0);
      step();
      step();
      chk("t4_nwr", log_q.size(), 0);

      // reset mid-load, then restart from index 0
      set_words(4);
      do_start(32'h80, 4);
      stream(32'h80, 4, 1'b0, 32'h0, 2);
      arst = 1'b1;
      exp_q.delete();
      #1;
      chk("t5_rst_outs", {s_ready, addr_ext, wen_ext, ren_ext, wdata_ext, cpu_enable, busy, done, error}, 0);
      step();
      arst = 1'b0;
      @(negedge clk);
      chk("t5_idle", {busy, cpu_enable, done}, 0);
      step();
      log_q.delete();
      do_start(32'h80, 4);
      stream(32'h80, 4, 1'b0, 32'h0, -1);
      finish_load(32'h80, 4, 1'b0);
      chk("t5_nwr", log_q.size(), 4);
      if (log_q.size() >= 4) begin
         chk("t5_a0", log_q[0].a, 32'h80);
         chk("t5_a3", log_q[3].a, 32'h8C);
      end
      do_stop();

      // address wrap at 2^32
      set_words(3);
      log_q.delete();
      do_start(32'hFFFF_FFF8, 3);
      stream(32'hFFFF_FFF8, 3, 1'b0, 32'h0, -1);
      finish_load(32'hFFFF_FFF8, 3, 1'b0);
      if (log_q.size() >= 3) begin
         chk("t6_a1", log_q[1].a, 32'hFFFF_FFFC);
         chk("t6_a2", log_q[2].a, 32'h0000_0000);
      end
      do_stop();

      // randomized loads
      for (int it = 0; it < 20; it++) begin
         n = $urandom_range(1, 12);
         base = $urandom & 32'hFFFF_FFFC;
         if ($urandom_range(0, 3) == 0) base = 32'hFFFF_FFE0 | ($urandom & 32'h1C);
         set_words(n);
         do_start(base, (ADDR_W+1)'(n));
         stream(base, n, 1'b0, 32'h0, -1);
         finish_load(base, n, 1'b0);
         do_stop();
      end

`ifdef IMEM_LOADER_VERIFY_EN
      // read-back corruption of word 1 must fail verification
      set_words(3);
      corrupt_en   = 1'b1;
      corrupt_addr = 32'h204;
      do_start(32'h200, 3);
      stream(32'h200, 3, 1'b0, 32'h0, -1);
      finish_load(32'h200, 3, 1'b1);
      corrupt_en = 1'b0;
      @(negedge clk);
      chk("t7_idle", {busy, cpu_enable, done}, 0);
      step();
`endif

      chk("final_queue_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
